// File: rtl/wb_stage_regfile.sv
// Writeback stage: load extension, writeback select, 32x32 register file with write-through read bypass.
// Optional WB_TRACE_EN macro enables a simulation-only trace line for every committed write.
module wb_stage_regfile #(
    parameter logic [31:0] RESET_VAL = 32'h0000_0000,
    parameter logic [31:0] LINK_OFS  = 32'd8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        RegWrite_wb,
    input  logic [1:0]  MemtoReg_wb,
    input  logic [31:0] dmout_wb,
    input  logic [31:0] aluout_wb,
    input  logic [29:0] pc_wb,
    input  logic [4:0]  a3_wb,
    input  logic [2:0]  Load_wb,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    output logic [31:0] wd_wb,
    output logic        we_eff
);

    logic [31:0] rf [0:31];
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;
    logic [31:0] link_val;

    assign we_eff = RegWrite_wb && (a3_wb != 5'd0);

    // Halfword select ignores aluout_wb[0]; misalignment is not trapped here.
    always_comb begin
        ld_byte = dmout_wb[7:0];
        case (aluout_wb[1:0])
            2'd0: ld_byte = dmout_wb[7:0];
            2'd1: ld_byte = dmout_wb[15:8];
            2'd2: ld_byte = dmout_wb[23:16];
            2'd3: ld_byte = dmout_wb[31:24];
            default: ld_byte = dmout_wb[7:0];
        endcase
        ld_half = aluout_wb[1] ? dmout_wb[31:16] : dmout_wb[15:0];
    end

    always_comb begin
        ld_ext = dmout_wb;
        case (Load_wb)
            3'd1: ld_ext = {24'd0, ld_byte};
            3'd2: ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'd3: ld_ext = {16'd0, ld_half};
            3'd4: ld_ext = {{16{ld_half[15]}}, ld_half};
            default: ld_ext = dmout_wb;
        endcase
    end

    assign link_val = {pc_wb, 2'b00} + LINK_OFS;

    always_comb begin
        wd_wb = aluout_wb;
        case (MemtoReg_wb)
            2'd1: wd_wb = ld_ext;
            2'd2: wd_wb = link_val;
            default: wd_wb = aluout_wb;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf[0] <= 32'd0;
            for (int i = 1; i < 32; i++) begin
                rf[i] <= RESET_VAL;
            end
        end else if (we_eff) begin
            rf[a3_wb] <= wd_wb;
        end
    end

    // Same-cycle writeback is forwarded so decode never reads a stale value.
    always_comb begin
        if (ra1 == 5'd0)
            rd1 = 32'd0;
        else if (we_eff && (a3_wb == ra1))
            rd1 = wd_wb;
        else
            rd1 = rf[ra1];

        if (ra2 == 5'd0)
            rd2 = 32'd0;
        else if (we_eff && (a3_wb == ra2))
            rd2 = wd_wb;
        else
            rd2 = rf[ra2];
    end

`ifdef WB_TRACE_EN
    always @(posedge clk) begin
        if (!reset && we_eff)
            $display("@%08h: $%0d <= %08h", {pc_wb, 2'b00}, a3_wb, wd_wb);
    end
`endif

endmodule
